popcnt_seq: RTL and testbench

POPCNT_SEQ -- requirements
Module: popcnt_seq

---
 rtl/popcnt_seq.sv | 137 +++++++++++++
 tb/tb_popcnt_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_seq.sv
// popcnt_seq: sequential population count.
// An accepted W-bit operand is counted CHUNK bits per cycle through one
// shared popcount slice. The result is presented after a fixed NCH cycles
// and held until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. On the input side, in_ready depends combinationally on
// abort and rst, so a producer may hold in_valid high while waiting. On the
// output side, out_valid stays high and out_count stays stable until the
// transfer edge, unless abort or rst cancels the result first.
module popcnt_seq #(
    parameter int W     = 128,
    parameter int CHUNK = 8,
    parameter int NCH   = W / CHUNK,
    parameter int CW    = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Chunk index width; at least one bit even when there is a single chunk.
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_shreg;
    logic [CW-1:0]   r_acc;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_chunk_pop;
    logic [CW-1:0]   w_sum;
    logic            w_accept;
    logic            w_last;

    assign in_ready  = (r_state == S_IDLE) && !abort && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign out_count = r_count;
    assign dbg_state = r_state;

    // Popcount of the low chunk of the shift register, plus the running sum.
    always_comb begin
        w_chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_chunk_pop = w_chunk_pop + CW'(r_shreg[i]);
        end
        w_sum = r_acc + w_chunk_pop;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort beats both the last-chunk step and the output transfer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, one chunk per BUSY cycle, publish final sum entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= in_data;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_BUSY: begin
                    // An aborted job freezes here; the next accept clears it.
                    if (!abort) begin
                        r_acc   <= w_sum;
                        r_shreg <= r_shreg >> CHUNK;
                        r_idx   <= r_idx + IW'(1);
                        if (w_last) begin
                            r_count <= w_sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcnt_seq.sv
// Testbench for popcnt_seq: table of known operands, hand-written corner
// sequences (backpressure, abort, reset mid-job), then randomized jobs
// checked against $countones and a fixed-latency expectation.
module tb_popcnt_seq;

    localparam int W     = 128;
    localparam int CHUNK = 8;
    localparam int NCH   = W / CHUNK;
    localparam int CW    = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    logic [CW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    popcnt_seq #(.W(W), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: v = v & {$urandom(), $urandom(), $urandom(), $urandom()};
            1: v = v | {$urandom(), $urandom(), $urandom(), $urandom()};
            default: ;
        endcase
        return v;
    endfunction

    // Driver: offer an operand and take it at the next edge; scramble in_data afterwards.
    task automatic accept(input logic [W-1:0] data, input string name);
        in_valid = 1'b1;
        in_data  = data;
        settle();
        check({name, "_in_ready"}, W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        in_data  = rand_word();
    endtask

    // Wait (bounded) for out_valid; report cycles since accept and busy cycles seen.
    task automatic wait_result(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        settle();
        while (!out_valid && lat < 200) begin
            if (busy) nb++;
            in_data = rand_word();
            step();
            settle();
            lat++;
        end
    endtask

    // Output transfer, then confirm IDLE with in_ready back up.
    task automatic handshake(input string name);
        out_ready = 1'b1;
        settle();
        step();
        out_ready = 1'b0;
        settle();
        check({name, "_post_valid"}, W'(out_valid), W'(0));
        check({name, "_post_ready"}, W'(in_ready), W'(1));
    endtask

    task automatic run_job(input logic [W-1:0] data, input logic [CW-1:0] exp, input string name);
        int lat;
        int nb;
        accept(data, name);
        wait_result(lat, nb);
        check({name, "_latency"}, W'(lat), W'(NCH));
        check({name, "_busy_cycles"}, W'(nb), W'(NCH));
        check({name, "_count"}, W'(out_count), W'(exp));
        handshake(name);
    endtask

    // Watch a span of cycles and count any out_valid pulses.
    task automatic expect_quiet(input int cycles, input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            settle();
            if (out_valid) pulses++;
            step();
        end
        check({name, "_no_result"}, W'(pulses), W'(0));
    endtask

    initial begin
        logic [W-1:0] d;
        int lat;
        int nb;
        int mode;
        int hold;
        int ab;
        logic [CW-1:0] exp_v;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{data: '0,                                     exp: CW'(0)};
        vecs[1] = '{data: {W{1'b1}},                              exp: CW'(128)};
        vecs[2] = '{data: 128'h8000_0000_0000_0001_0000_0000_0000_0F0F, exp: CW'(10)};
        vecs[3] = '{data: 128'h3,                                 exp: CW'(2)};
        vecs[4] = '{data: 128'hFF,                                exp: CW'(8)};
        vecs[5] = '{data: 128'h8000_0000_0000_0000_0000_0000_0000_0000, exp: CW'(1)};
        vecs[6] = '{data: 128'h5555_5555_5555_5555_5555_5555_5555_5555, exp: CW'(64)};
        vecs[7] = '{data: 128'h0123_4567_89AB_CDEF_0000_0000_0000_0000, exp: CW'(32)};

        // Reset state
        step();
        step();
        settle();
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_count", W'(out_count), W'(0));
        check("rst_busy", W'(busy), W'(0));
        rst = 1'b0;
        settle();
        check("post_rst_in_ready", W'(in_ready), W'(1));

        // Table of known operands
        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: five held cycles in DONE
        accept(128'hF0F0, "bp");
        wait_result(lat, nb);
        check("bp_latency", W'(lat), W'(NCH));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_hold_count", W'(out_count), W'(8));
            check("bp_hold_in_ready", W'(in_ready), W'(0));
            step();
            settle();
        end
        handshake("bp");

        // Abort in BUSY cycle 7, then a fresh job must not inherit the partial sum
        accept({W{1'b1}}, "abort7");
        repeat (6) step();
        abort = 1'b1;
        settle();
        check("abort7_busy", W'(busy), W'(1));
        check("abort7_in_ready", W'(in_ready), W'(0));
        step();
        abort = 1'b0;
        settle();
        check("abort7_idle_busy", W'(busy), W'(0));
        check("abort7_idle_ready", W'(in_ready), W'(1));
        expect_quiet(NCH + 4, "abort7");
        run_job(128'h3, CW'(2), "after_abort");

        // Abort on the last BUSY cycle must not publish a result
        accept(128'hFFFF, "abort_last");
        repeat (NCH - 1) step();
        abort = 1'b1;
        settle();
        check("abort_last_busy", W'(busy), W'(1));
        step();
        abort = 1'b0;
        settle();
        check("abort_last_valid", W'(out_valid), W'(0));
        check("abort_last_count_held", W'(out_count), W'(2));
        expect_quiet(4, "abort_last");

        // Abort beats a same-cycle output transfer
        accept(128'h7, "abort_hs");
        wait_result(lat, nb);
        check("abort_hs_count", W'(out_count), W'(3));
        abort     = 1'b1;
        out_ready = 1'b1;
        settle();
        check("abort_hs_in_ready", W'(in_ready), W'(0));
        step();
        abort     = 1'b0;
        out_ready = 1'b0;
        settle();
        check("abort_hs_valid", W'(out_valid), W'(0));
        check("abort_hs_ready", W'(in_ready), W'(1));

        // Abort in IDLE blocks acceptance only
        in_valid = 1'b1;
        in_data  = 128'h1;
        abort    = 1'b1;
        settle();
        check("abort_idle_ready", W'(in_ready), W'(0));
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        settle();
        check("abort_idle_busy", W'(busy), W'(0));
        check("abort_idle_ready_after", W'(in_ready), W'(1));

        // Reset during BUSY cycle 10
        accept(128'hABCD, "rst_mid");
        repeat (9) step();
        rst = 1'b1;
        settle();
        check("rst_mid_in_ready", W'(in_ready), W'(0));
        step();
        settle();
        check("rst_mid_valid", W'(out_valid), W'(0));
        check("rst_mid_count", W'(out_count), W'(0));
        check("rst_mid_busy", W'(busy), W'(0));
        rst = 1'b0;
        settle();
        check("rst_mid_ready", W'(in_ready), W'(1));
        expect_quiet(NCH + 4, "rst_mid");

        // Reset in DONE discards the result
        accept(128'hF, "rst_done");
        wait_result(lat, nb);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("rst_done_valid", W'(out_valid), W'(0));
        check("rst_done_ready", W'(in_ready), W'(1));

        // Randomized jobs against $countones with a fixed latency
        for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 2)) step();
            d = rand_word();
            mode = $urandom_range(0, 3);
            accept(d, "rnd");
            exp_q.push_back(CW'($countones(d)));
            if (mode == 3) begin
                ab = $urandom_range(0, NCH + 2);
                repeat (ab) step();
                abort = 1'b1;
                step();
                abort = 1'b0;
                settle();
                check("rnd_abort_valid", W'(out_valid), W'(0));
                check("rnd_abort_ready", W'(in_ready), W'(1));
                void'(exp_q.pop_back());
            end else begin
                wait_result(lat, nb);
                check("rnd_latency", W'(lat), W'(NCH));
                hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) begin
                    step();
                    settle();
                    check("rnd_hold_valid", W'(out_valid), W'(1));
                end
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("rnd_count", W'(out_count), W'(exp_v));
                end else begin
                    check("rnd_queue_empty", W'(1), W'(0));
                end
                handshake("rnd");
            end
        end
        check("rnd_queue_drained", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the run always ends with a summary.
    initial begin
        #2000000;
        n_total++;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
